// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the multiply/divide unit.
//   start  : one-cycle request; ctrl, A and B are sampled with it
//   ctrl   : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B   : rs / rt operands
//   busy   : a mult/div is in flight
//   done   : one-cycle pulse in the cycle after HI/LO take a mult/div result
//   hi, lo : architectural HI/LO registers
// master = EX stage / hazard unit side, slave = the MDU.
interface mdu_if;
   logic        start;
   logic [2:0]  ctrl;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, ctrl, A, B, input busy, done, hi, lo);
   modport slave  (input start, ctrl, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit that owns the HI/LO registers.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mdu_if slave (start/ctrl/A/B in; busy/done/hi/lo out)
// Operands are latched on an accepted start. The result is computed from the
// latched operands and only written to HI/LO on the last RUN edge, so the old
// HI/LO stay readable for the whole busy window.
module mdu #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic  clk,
   input  logic  reset,
   mdu_if.slave  bus
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

   typedef enum logic {IDLE, RUN} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   // datapath on latched operands
   logic        is_signed, is_mult;
   logic [63:0] mul_a, mul_b, prod;
   logic        neg_a, neg_b;
   logic [31:0] ua, ub, q_u, r_u, quo, rem;

   always_comb begin
      is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
      is_mult   = (op_q == OP_MULT) || (op_q == OP_MULTU);

      // Extending to 64 bits and keeping the low half of the product gives
      // the exact signed or unsigned 32x32 result with one multiplier.
      mul_a = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
      mul_b = is_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
      prod  = mul_a * mul_b;

      // Divide on magnitudes, then fix signs: quotient truncates toward zero,
      // remainder follows the dividend. 0x80000000 / -1 falls out as
      // 0x80000000 rem 0 because the magnitude is taken as unsigned.
      neg_a = is_signed && a_q[31];
      neg_b = is_signed && b_q[31];
      ua    = neg_a ? (~a_q + 32'd1) : a_q;
      ub    = neg_b ? (~b_q + 32'd1) : b_q;
      q_u   = (ub != 32'd0) ? (ua / ub) : 32'd0;
      r_u   = (ub != 32'd0) ? (ua % ub) : 32'd0;
      quo   = (neg_a ^ neg_b) ? (~q_u + 32'd1) : q_u;
      rem   = neg_a ? (~r_u + 32'd1) : r_u;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.ctrl)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     op_d    = bus.ctrl;
                     a_d     = bus.A;
                     b_d     = bus.B;
                     cnt_d   = ((bus.ctrl == OP_MULT) || (bus.ctrl == OP_MULTU)) ? MULT_CNT : DIV_CNT;
                     state_d = RUN;
                  end
                  OP_MTHI: hi_d = bus.A;
                  OP_MTLO: lo_d = bus.A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // start is ignored here, mthi/mtlo included
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (is_mult) begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end else if (b_q != 32'd0) begin
                  // divide by zero keeps HI/LO
                  hi_d = rem;
                  lo_d = quo;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for mdu. Expected HI/LO are pushed to a queue when a
// mult/div is issued and popped when done is seen.
module tb_mdu;
   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   mdu_if bus ();

   mdu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] scb[$];
   logic [31:0] cur_hi = 32'd0;
   logic [31:0] cur_lo = 32'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model, 64-bit arithmetic so the signed overflow case needs no special handling.
   function automatic logic [63:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      longint sa, sbv, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      p   = {cur_hi, cur_lo};
      case (c)
         3'd1: p = 64'(sa * sbv);
         3'd2: p = {32'b0, a} * {32'b0, b};
         3'd3: if (b != 0) begin
            q = sa / sbv;
            r = sa % sbv;
            p = {r[31:0], q[31:0]};
         end
         3'd4: if (b != 0) p = {a % b, a / b};
         default: ;
      endcase
      return p;
   endfunction

   task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit acc, input bit wait_edge);
      if (wait_edge) @(negedge clk);
      bus.start = 1'b1;
      bus.ctrl  = c;
      bus.A     = a;
      bus.B     = b;
      if (acc) begin
         if (c >= 3'd1 && c <= 3'd4) scb.push_back(model(c, a, b));
         else if (c == 3'd5) cur_hi = a;
         else if (c == 3'd6) cur_lo = a;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.start = 1'b0;
      bus.ctrl  = 3'd0;
   endtask

   task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      drive(c, a, b, 1'b1, 1'b1);
      idle();
   endtask

   // Counts busy cycles from the current negedge; returns at the done cycle.
   task automatic wait_result(input string tag, input int exp_busy);
      int nb;
      logic [63:0] e;
      nb = 0;
      while (bus.busy === 1'b1 && nb < 40) begin
         chk({tag, "_hold"}, {bus.hi, bus.lo}, {cur_hi, cur_lo});
         nb++;
         @(negedge clk);
      end
      chk({tag, "_busy"}, 64'(nb), 64'(exp_busy));
      chk({tag, "_done"}, 64'(bus.done), 64'd1);
      if (scb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s_scb: observed empty queue expected an entry", tag);
      end else begin
         e = scb.pop_front();
         chk({tag, "_hilo"}, {bus.hi, bus.lo}, e);
         cur_hi = e[63:32];
         cur_lo = e[31:0];
      end
   endtask

   task automatic quiet(input string tag);
      @(negedge clk);
      chk({tag, "_done_low"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.ctrl  = 3'd0;
      bus.A     = 32'd0;
      bus.B     = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      reset = 1'b1;

      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      wait_result("mult", MULT_LAT);
      quiet("mult");

      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result("multu", MULT_LAT);
      quiet("multu");

      // divu issued in the same cycle the div's done is high
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_result("div", DIV_LAT);
      drive(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      idle();
      wait_result("divu", DIV_LAT);
      quiet("divu");

      drive(3'd5, 32'h1234_5678, 32'd0, 1'b1, 1'b1);
      drive(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b1);
      idle();
      chk("mthilo_busy", 64'(bus.busy), 64'd0);
      chk("mthilo_val", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

      issue(3'd3, 32'd55, 32'd0);
      wait_result("div0", DIV_LAT);
      quiet("div0");

      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("divovf", DIV_LAT);
      quiet("divovf");

      // mtlo and div during busy must be dropped
      issue(3'd1, 32'd7, 32'd6);
      drive(3'd6, 32'h0000_DEAD, 32'd0, 1'b0, 1'b1);
      drive(3'd3, 32'd100, 32'd3, 1'b0, 1'b1);
      idle();
      wait_result("ign", MULT_LAT - 3);
      quiet("ign");

      // asynchronous reset in the middle of a divide
      issue(3'd3, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
      scb.delete();
      cur_hi = 32'd0;
      cur_lo = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < DIV_LAT + 3; i++) begin
         @(negedge clk);
         chk("post_rst_done", 64'(bus.done), 64'd0);
         chk("post_rst_hilo", {bus.hi, bus.lo}, 64'd0);
      end

      issue(3'd1, 32'h0001_0000, 32'h0001_0000);
      wait_result("mult_post", MULT_LAT);
      quiet("mult_post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
